// File: rtl/isa_pkg.sv
// Shared ISA constants for the five-stage core:
// opcodes, ALU ops, special registers and exception codes.
package isa_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_RA      = 5'd31;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADD  = 3'd1;
    localparam logic [2:0] EXC_ADDI = 3'd2;
    localparam logic [2:0] EXC_SUB  = 3'd3;
    localparam logic [2:0] EXC_MUL  = 3'd4;
    localparam logic [2:0] EXC_DIV  = 3'd5;

    // Which value the write port carries
    typedef enum logic [2:0] {
        SRC_ALU,
        SRC_MEM,
        SRC_PC,
        SRC_T,
        SRC_CODE
    } wb_src_e;

endpackage

// File: rtl/wb_decode.sv
// Writeback decode: destination, write enable, data source
// and exception status code for the instruction in MW.
module wb_decode
    import isa_pkg::*;
(
    input  logic [31:0] insn,
    input  logic        exception,
    output logic        we,
    output logic [4:0]  dest,
    output wb_src_e     src,
    output logic [2:0]  code
);

    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] aluop;
    logic       unused_fields;

    assign opcode = insn[31:27];
    assign rd     = insn[26:22];
    assign aluop  = insn[6:2];
    assign unused_fields = ^{insn[21:7], insn[1:0]};

    // Per-opcode write decode; an arithmetic exception redirects to $rstatus
    always_comb begin
        we   = 1'b0;
        dest = 5'd0;
        src  = SRC_ALU;
        code = EXC_NONE;
        case (opcode)
            OP_RTYPE: begin
                we   = 1'b1;
                dest = rd;
                src  = SRC_ALU;
                if (exception) begin
                    case (aluop)
                        ALU_ADD: code = EXC_ADD;
                        ALU_SUB: code = EXC_SUB;
                        ALU_MUL: code = EXC_MUL;
                        ALU_DIV: code = EXC_DIV;
                        default: code = EXC_NONE;
                    endcase
                end
            end
            OP_ADDI: begin
                we   = 1'b1;
                dest = rd;
                src  = SRC_ALU;
                if (exception) begin
                    code = EXC_ADDI;
                end
            end
            OP_LW: begin
                we   = 1'b1;
                dest = rd;
                src  = SRC_MEM;
            end
            OP_JAL: begin
                we   = 1'b1;
                dest = REG_RA;
                src  = SRC_PC;
            end
            OP_SETX: begin
                we   = 1'b1;
                dest = REG_RSTATUS;
                src  = SRC_T;
            end
            default: begin
                we = 1'b0;
            end
        endcase
        if (code != EXC_NONE) begin
            dest = REG_RSTATUS;
            src  = SRC_CODE;
        end
        if (dest == 5'd0) begin
            we = 1'b0;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// MW pipeline register, register-file write port and
// retired-instruction counter for the final pipeline stage.
module writeback_stage
    import isa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGS  = 32,
    localparam int RIDX = $clog2(REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             xm_valid,
    input  logic [31:0]      xm_insn,
    input  logic [WIDTH-1:0] xm_alu_result,
    input  logic [WIDTH-1:0] xm_pc_plus1,
    input  logic             xm_exception,
    input  logic [WIDTH-1:0] dmem_q,
    output logic             ctrl_writeEnable,
    output logic [RIDX-1:0]  ctrl_writeReg,
    output logic [WIDTH-1:0] data_writeReg,
    output logic             mw_valid,
    output logic [31:0]      mw_insn,
    output logic [31:0]      retired
);

    logic             valid_q;
    logic [31:0]      insn_q;
    logic [WIDTH-1:0] alu_q;
    logic [WIDTH-1:0] pc1_q;
    logic             exc_q;
    logic [31:0]      retired_q;

    logic             dec_we;
    logic [4:0]       dec_dest;
    wb_src_e          dec_src;
    logic [2:0]       dec_code;
    logic [WIDTH-1:0] wdata_d;

    // MW register: reset, then flush, then stall, then load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            alu_q   <= '0;
            pc1_q   <= '0;
            exc_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            alu_q   <= '0;
            pc1_q   <= '0;
            exc_q   <= 1'b0;
        end else if (!stall) begin
            valid_q <= xm_valid;
            insn_q  <= xm_insn;
            alu_q   <= xm_alu_result;
            pc1_q   <= xm_pc_plus1;
            exc_q   <= xm_exception;
        end
    end

    // Count each valid instruction as it leaves MW
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (valid_q && !stall) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    wb_decode u_dec (
        .insn      (insn_q),
        .exception (exc_q),
        .we        (dec_we),
        .dest      (dec_dest),
        .src       (dec_src),
        .code      (dec_code)
    );

    // Write-data source mux
    always_comb begin
        wdata_d = alu_q;
        case (dec_src)
            SRC_ALU:  wdata_d = alu_q;
            SRC_MEM:  wdata_d = dmem_q;
            SRC_PC:   wdata_d = pc1_q;
            SRC_T:    wdata_d = {{(WIDTH-27){1'b0}}, insn_q[26:0]};
            SRC_CODE: wdata_d = {{(WIDTH-3){1'b0}}, dec_code};
            default:  wdata_d = alu_q;
        endcase
    end

    // Idle write port reads as all-zero so forwarding never matches
    always_comb begin
        ctrl_writeEnable = valid_q && dec_we;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (ctrl_writeEnable) begin
            ctrl_writeReg = RIDX'(dec_dest);
            data_writeReg = wdata_d;
        end
    end

    assign mw_valid = valid_q;
    assign mw_insn  = insn_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed instructions
// with hand-computed write-port results.
module tb_writeback_stage;
    import isa_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        xm_valid;
    logic [31:0] xm_insn;
    logic [31:0] xm_alu_result;
    logic [31:0] xm_pc_plus1;
    logic        xm_exception;
    logic [31:0] dmem_q;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        mw_valid;
    logic [31:0] mw_insn;
    logic [31:0] retired;

    writeback_stage dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .xm_valid         (xm_valid),
        .xm_insn          (xm_insn),
        .xm_alu_result    (xm_alu_result),
        .xm_pc_plus1      (xm_pc_plus1),
        .xm_exception     (xm_exception),
        .dmem_q           (dmem_q),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .mw_valid         (mw_valid),
        .mw_insn          (mw_insn),
        .retired          (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        string       nm;
        logic        valid;
        logic [31:0] insn;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd,
                                          input logic [4:0] aluop);
        rtype = {OP_RTYPE, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op,
                                          input logic [4:0] rd,
                                          input logic [16:0] imm);
        itype = {op, rd, 5'd1, imm};
    endfunction

    // Drive one XM instruction and queue the MW result for the next edge
    task automatic issue(input string nm, input logic v,
                         input logic [31:0] insn, input logic [31:0] alu,
                         input logic [31:0] pc, input logic exc,
                         input logic st, input logic fl,
                         input logic ev, input logic [31:0] ei,
                         input logic ewe, input logic [4:0] erd,
                         input logic [31:0] ed, input logic [31:0] eret);
        exp_t e;
        @(negedge clock);
        xm_valid      = v;
        xm_insn       = insn;
        xm_alu_result = alu;
        xm_pc_plus1   = pc;
        xm_exception  = exc;
        stall         = st;
        flush         = fl;
        e.cyc   = cyc + 1;
        e.nm    = nm;
        e.valid = ev;
        e.insn  = ei;
        e.we    = ewe;
        e.rd    = erd;
        e.data  = ed;
        e.ret   = eret;
        sb.push_back(e);
    endtask

    // Monitor: compare whatever the DUT presents against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    total++;
                    $display("FAIL %s_late: due %0d now %0d", e.nm, e.cyc, cyc);
                end else begin
                    chk({e.nm, "_valid"}, 32'(mw_valid), 32'(e.valid));
                    chk({e.nm, "_insn"}, mw_insn, e.insn);
                    chk({e.nm, "_we"}, 32'(ctrl_writeEnable), 32'(e.we));
                    chk({e.nm, "_reg"}, 32'(ctrl_writeReg), 32'(e.rd));
                    chk({e.nm, "_data"}, data_writeReg, e.data);
                    chk({e.nm, "_ret"}, retired, e.ret);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] i_add, i_lw, i_jal, i_setx, i_addx, i_div;
        logic [31:0] i_a0, i_sw, i_sub, i_mul, i_addi, i_a9;
        logic [31:0] i_a7, i_a8;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        xm_valid = 1'b0;
        xm_insn = '0;
        xm_alu_result = '0;
        xm_pc_plus1 = '0;
        xm_exception = 1'b0;
        dmem_q = '0;
        #2 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(mw_valid), 32'd0);
        chk("rst_insn", mw_insn, 32'd0);
        chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
        chk("rst_reg", 32'(ctrl_writeReg), 32'd0);
        chk("rst_data", data_writeReg, 32'd0);
        chk("rst_ret", retired, 32'd0);
        reset = 1'b0;

        i_add  = rtype(5'd3, ALU_ADD);
        i_lw   = itype(OP_LW, 5'd5, 17'd0);
        i_jal  = {OP_JAL, 27'h100};
        i_setx = {OP_SETX, 27'h7FFFFFF};
        i_addx = rtype(5'd4, ALU_ADD);
        i_div  = rtype(5'd4, ALU_DIV);
        i_a0   = itype(OP_ADDI, 5'd0, 17'd9);
        i_sw   = itype(OP_SW, 5'd2, 17'd4);
        i_sub  = rtype(5'd6, ALU_SUB);
        i_mul  = rtype(5'd7, ALU_MUL);
        i_addi = itype(OP_ADDI, 5'd8, 17'd1);
        i_a9   = itype(OP_ADDI, 5'd9, 17'd55);
        i_a7   = rtype(5'd7, ALU_ADD);
        i_a8   = rtype(5'd8, ALU_ADD);

        dmem_q = 32'hDEADBEEF;
        issue("add", 1, i_add, 7, 1, 0, 0, 0, 1, i_add, 1, 3, 7, 0);
        issue("lw", 1, i_lw, 32'h40, 2, 0, 0, 0,
              1, i_lw, 1, 5, 32'hDEADBEEF, 1);
        issue("jal", 1, i_jal, 0, 32'h12, 0, 0, 0,
              1, i_jal, 1, 31, 32'h12, 2);
        issue("setx", 1, i_setx, 0, 4, 0, 0, 0,
              1, i_setx, 1, 30, 32'h07FFFFFF, 3);
        issue("addexc", 1, i_addx, 5, 5, 1, 0, 0, 1, i_addx, 1, 30, 1, 4);
        issue("divexc", 1, i_div, 5, 6, 1, 0, 0, 1, i_div, 1, 30, 5, 5);
        issue("addi_r0", 1, i_a0, 9, 7, 0, 0, 0, 1, i_a0, 0, 0, 0, 6);
        issue("sw", 1, i_sw, 8, 8, 0, 0, 0, 1, i_sw, 0, 0, 0, 7);
        issue("subexc", 1, i_sub, 1, 9, 1, 0, 0, 1, i_sub, 1, 30, 3, 8);
        issue("mulexc", 1, i_mul, 1, 10, 1, 0, 0, 1, i_mul, 1, 30, 4, 9);
        issue("addiexc", 1, i_addi, 1, 11, 1, 0, 0, 1, i_addi, 1, 30, 2, 10);
        issue("add2", 1, i_add, 7, 12, 0, 0, 0, 1, i_add, 1, 3, 7, 11);
        issue("stall1", 1, i_a9, 55, 13, 0, 1, 0, 1, i_add, 1, 3, 7, 11);
        issue("stall2", 1, i_a9, 55, 13, 0, 1, 0, 1, i_add, 1, 3, 7, 11);
        issue("stall3", 1, i_a9, 55, 13, 0, 1, 0, 1, i_add, 1, 3, 7, 11);
        issue("flush_st", 1, i_a9, 55, 13, 0, 1, 1, 0, 0, 0, 0, 0, 11);
        issue("bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11);
        issue("inval", 0, i_a7, 3, 0, 0, 0, 0, 0, i_a7, 0, 0, 0, 11);
        issue("add8", 1, i_a8, 32'h33, 14, 0, 0, 0,
              1, i_a8, 1, 8, 32'h33, 11);

        @(negedge clock);
        xm_valid = 1'b0;
        xm_insn  = '0;
        #1 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(mw_valid), 32'd0);
        chk("arst_insn", mw_insn, 32'd0);
        chk("arst_we", 32'(ctrl_writeEnable), 32'd0);
        chk("arst_reg", 32'(ctrl_writeReg), 32'd0);
        chk("arst_data", data_writeReg, 32'd0);
        chk("arst_ret", retired, 32'd0);
        #1 reset = 1'b0;

        issue("post_add", 1, i_add, 7, 1, 0, 0, 0, 1, i_add, 1, 3, 7, 0);
        issue("post_bub", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        repeat (3) @(negedge clock);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
